// File: rtl/fifo_stream_out_if.sv
// Stream-out bundle: FIFO pop side (empty/read/rd_data), flush, and the
// downstream valid/ready stream. master = drain stage, slave = its environment.
interface fifo_stream_out_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  empty;
  logic                  read;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  flush;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  empty, rd_data, flush, out_ready,
    output read, out_data, out_valid
  );

  modport slave (
    output empty, rd_data, flush, out_ready,
    input  read, out_data, out_valid
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Read-side drain stage: pops the FIFO, absorbs RAM read latency in a skid
// buffer and presents words on a lossless, ordered valid/ready stream.
module fifo_stream_out #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = READ_LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_stream_out_if.master     bus,
  output logic                  idle
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SW = CW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DATA_WIDTH-1:0]   skid_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]   skid_d [BUF_DEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [READ_LATENCY-1:0] pend_q, pend_d;
  state_t                  state_q, state_d;

  logic          valid, pop, rd, cap, clr;
  logic [SW-1:0] inflight, occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid         = (count_q != '0);
  assign pop           = valid & bus.out_ready;
  assign clr           = reset | bus.flush;
  assign bus.out_valid = valid;
  assign bus.out_data  = skid_q[head_q];
  assign bus.read      = rd;
  assign idle          = (state_q == IDLE);

  // Issue credit counts the word leaving this cycle, so out_ready reaches read.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + SW'(pend_q[i]);
    occ = {1'b0, count_q} + inflight - SW'(pop);
    rd  = !clr && !bus.empty && (occ < SW'(BUF_DEPTH));
  end

  always_comb begin
    skid_d  = skid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cap     = pend_q[READ_LATENCY-1] & ~clr;
    pend_d  = '0;
    pend_d[0] = rd;
    for (int i = 1; i < READ_LATENCY; i++) pend_d[i] = pend_q[i-1];
    if (cap) begin
      skid_d[tail_q] = bus.rd_data;
      tail_d         = nxt(tail_q);
    end
    if (pop) head_d = nxt(head_q);
    count_d = count_q + CW'(cap) - CW'(pop);
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = '0;
    end
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) skid_d[i] = '0;
    end
  end

  // Debug-only activity tracker; the datapath never looks at it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd) state_d = ACTIVE;
      ACTIVE:  if (count_d == '0 && pend_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    skid_q  <= skid_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
    pend_q  <= pend_d;
    state_q <= state_d;
  end
endmodule

// File: tb/tb_fifo_stream_out.sv
// Randomized bench for fifo_stream_out: a delayed-counter RAM feeds the DUT and
// a queue of issued-but-undelivered words predicts read, valid, data and idle.
module tb_fifo_stream_out;
  localparam int DW = 8, RL = 2, BD = 3;

  logic clk = 1'b0;
  logic reset, idle;
  always #5 clk = ~clk;

  fifo_stream_out_if #(.DATA_WIDTH(DW)) bus();

  fifo_stream_out #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .BUF_DEPTH(BD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .idle (idle)
  );

  // RAM: each pop returns the next counter value RL cycles later
  logic [DW-1:0] ram_pipe [RL];
  logic [DW-1:0] ram_cnt = 8'h10;
  assign bus.rd_data = ram_pipe[RL-1];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
    ram_pipe[0] <= bus.read ? ram_cnt : 8'hEE;
    if (bus.read) ram_cnt <= ram_cnt + 1'b1;
  end

  // Reference: every issued word with its issue cycle, oldest first
  typedef struct {logic [DW-1:0] d; int t;} ent_t;
  ent_t          q[$];
  logic [DW-1:0] m_cnt = 8'h10;
  int            cyc = 0, n_chk = 0, n_pass = 0;
  bit            prev_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
  endtask

  task automatic step(input bit r, input bit f, input bit e, input bit rdy);
    bit exp_v, exp_rd, pop;
    int occ;
    reset         = r;
    bus.flush     = f;
    bus.empty     = e;
    bus.out_ready = rdy;
    #4;
    exp_v  = (q.size() > 0) && (q[0].t + RL + 1 <= cyc);
    pop    = exp_v && rdy;
    occ    = q.size() - (pop ? 1 : 0);
    exp_rd = !r && !f && !e && (occ < BD);
    chk("read", 32'(bus.read), 32'(exp_rd));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    if (exp_v) chk("out_data", 32'(bus.out_data), 32'(q[0].d));
    if (prev_rst) chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("idle", 32'(idle), 32'(q.size() == 0));
    if (r || f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (exp_rd) q.push_back('{d: m_cnt, t: cyc});
    end
    if (exp_rd) m_cnt = m_cnt + 1'b1;
    prev_rst = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.empty     = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (2)  step(1, 0, 0, 0);              // reset
    repeat (20) step(0, 0, 0, 1);              // streaming
    repeat (6)  step(0, 0, 0, 0);              // back-pressure
    repeat (8)  step(0, 0, 0, 1);
    repeat (5)  step(0, 0, 1, 1);              // empty gating
    repeat (6)  step(0, 0, 0, 1);
    repeat (4)  step(0, 0, 1, 1);              // drain, then flush mid-flight
    repeat (3)  step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (6)  step(0, 0, 0, 1);
    repeat (4)  step(0, 0, 1, 1);              // drain, then reset mid-flight
    repeat (3)  step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (6)  step(0, 0, 0, 1);
    repeat (1500)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    repeat (300)
      step(1'b0, 1'b0, $urandom_range(0, 7) < 5, $urandom_range(0, 3) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
